div16_by8: RTL and testbench

- Iterative restoring unsigned divider; inverse of the 8x8 multiplier datapath.
- Divides a 2*DW-bit dividend by a DW-bit divisor, giving a DW-bit quotient and a DW-bit remainder.
- Sits beside the multiplier in systolic PE post-processing (normalisation/scaling).
- Valid/ready handshake on both the input and the output side.

---
 rtl/div16_by8_pkg.sv | 16 +
 rtl/div16_by8_step.sv | 29 ++
 rtl/div16_by8.sv | 180 ++++++++++++++++++
 tb/tb_div16_by8.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/div16_by8_pkg.sv
// Shared definitions for the div16_by8 restoring divider: default width, FSM states,
// counter width and the quotient value reported on error.
package div_pkg;

    localparam int unsigned DW    = 8;
    localparam int unsigned CNT_W = $clog2(DW) + 1;

    localparam logic [DW-1:0] ERR_Q = '1;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

endpackage

// File: rtl/div16_by8_step.sv
// One combinational restoring-division step: shift the next dividend bit into the
// partial remainder, subtract the divisor when it fits, and record the quotient bit.
module div_step #(
    parameter int unsigned DW = 8
) (
    input  logic [DW-1:0] r_i,
    input  logic [DW-1:0] q_i,
    input  logic [DW-1:0] d_i,
    output logic [DW-1:0] r_o,
    output logic [DW-1:0] q_o
);

    logic [DW:0] t;
    logic [DW:0] diff;

    always_comb begin
        t    = {r_i, q_i[DW-1]};
        diff = t - {1'b0, d_i};
        if (t >= {1'b0, d_i}) begin
            // r_i < d_i on entry, so the difference always fits in DW bits
            r_o = diff[DW-1:0];
            q_o = {q_i[DW-2:0], 1'b1};
        end else begin
            r_o = t[DW-1:0];
            q_o = {q_i[DW-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/div16_by8.sv
// Iterative restoring unsigned divider, 2*DW-bit dividend by DW-bit divisor, with
// valid/ready handshakes. Define DIV_RADIX4_EN for two quotient bits per clock.
module div16_by8
    import div_pkg::*;
#(
    parameter int unsigned DW = div_pkg::DW
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2*DW-1:0] dividend,
    input  logic [DW-1:0]   divisor,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [DW-1:0]   quotient,
    output logic [DW-1:0]   remainder,
    output logic            div_by_zero,
    output logic            overflow
);

    localparam int unsigned CW = $clog2(DW) + 1;

`ifdef DIV_RADIX4_EN
    localparam int unsigned SPC = 2;
`else
    localparam int unsigned SPC = 1;
`endif

    state_t        state_q, state_d;
    logic [DW-1:0] r_q, r_d;
    logic [DW-1:0] q_q, q_d;
    logic [DW-1:0] d_q, d_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] quot_q, quot_d;
    logic [DW-1:0] rem_q, rem_d;
    logic          dbz_q, dbz_d;
    logic          ovf_q, ovf_d;

    logic [DW-1:0] step_r_in, step_q_in, step_d_in;
    logic [DW-1:0] step_r, step_q;
    logic [CW-1:0] cnt_nx;

    // The step datapath also runs on the accepting edge (fed straight from the
    // operand ports), so the first restoring step costs no extra cycle.
    always_comb begin
        if (state_q == IDLE) begin
            step_r_in = dividend[2*DW-1:DW];
            step_q_in = dividend[DW-1:0];
            step_d_in = divisor;
        end else begin
            step_r_in = r_q;
            step_q_in = q_q;
            step_d_in = d_q;
        end
    end

`ifdef DIV_RADIX4_EN
    logic [DW-1:0] mid_r, mid_q;

    div_step #(.DW(DW)) u_step0 (
        .r_i (step_r_in),
        .q_i (step_q_in),
        .d_i (step_d_in),
        .r_o (mid_r),
        .q_o (mid_q)
    );

    div_step #(.DW(DW)) u_step1 (
        .r_i (mid_r),
        .q_i (mid_q),
        .d_i (step_d_in),
        .r_o (step_r),
        .q_o (step_q)
    );
`else
    div_step #(.DW(DW)) u_step0 (
        .r_i (step_r_in),
        .q_i (step_q_in),
        .d_i (step_d_in),
        .r_o (step_r),
        .q_o (step_q)
    );
`endif

    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        q_d     = q_q;
        d_d     = d_q;
        cnt_d   = cnt_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;
        ovf_d   = ovf_q;
        cnt_nx  = cnt_q + CW'(SPC);

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    if (divisor == '0) begin
                        state_d = DONE;
                        quot_d  = '1;
                        rem_d   = '0;
                        dbz_d   = 1'b1;
                        ovf_d   = 1'b0;
                    end else if (dividend[2*DW-1:DW] >= divisor) begin
                        state_d = DONE;
                        quot_d  = '1;
                        rem_d   = '0;
                        dbz_d   = 1'b0;
                        ovf_d   = 1'b1;
                    end else begin
                        r_d     = step_r;
                        q_d     = step_q;
                        d_d     = divisor;
                        cnt_d   = CW'(SPC);
                        dbz_d   = 1'b0;
                        ovf_d   = 1'b0;
                        if (SPC >= DW) begin
                            state_d = DONE;
                            quot_d  = step_q;
                            rem_d   = step_r;
                        end else begin
                            state_d = CALC;
                        end
                    end
                end
            end
            CALC: begin
                r_d   = step_r;
                q_d   = step_q;
                cnt_d = cnt_nx;
                if (cnt_nx >= CW'(DW)) begin
                    state_d = DONE;
                    quot_d  = step_q;
                    rem_d   = step_r;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            r_q     <= '0;
            q_q     <= '0;
            d_q     <= '0;
            cnt_q   <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            q_q     <= q_d;
            d_q     <= d_d;
            cnt_q   <= cnt_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
            ovf_q   <= ovf_d;
        end
    end

    assign in_ready    = (state_q == IDLE);
    assign out_valid   = (state_q == DONE);
    assign quotient    = quot_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;
    assign overflow    = ovf_q;

endmodule

// File: tb/tb_div16_by8.sv
// Directed and multiplier round-trip checks for div16_by8 (radix-2 or DIV_RADIX4_EN build).
module tb_div16_by8;

`ifdef DIV_RADIX4_EN
    localparam int NLAT = 4;
`else
    localparam int NLAT = 8;
`endif
    localparam int TMO = 50;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] dividend;
    logic [7:0]  divisor;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  quotient;
    logic [7:0]  remainder;
    logic        div_by_zero;
    logic        overflow;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    div16_by8 dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero),
        .overflow    (overflow)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp)
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        else
            n_pass++;
    endtask

    // Present operands for one accepting edge, then count edges until out_valid.
    task automatic run_op(input logic [15:0] a, input logic [7:0] b, output int lat);
        @(negedge clk);
        in_valid = 1'b1;
        dividend = a;
        divisor  = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        dividend = 16'($urandom);
        divisor  = 8'($urandom);
        lat = 1;
        while (!out_valid && lat < TMO) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic finish_op();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic directed(input string tag, input logic [15:0] a, input logic [7:0] b,
                            input logic [7:0] eq, input logic [7:0] er,
                            input logic edz, input logic eov, input int elat);
        int lat;
        run_op(a, b, lat);
        check({tag, "_lat"}, lat, elat);
        check({tag, "_res"}, {eov, edz, er, eq}, {eov, edz, er, eq} & 18'h3FFFF);
        check({tag, "_out"}, {overflow, div_by_zero, remainder, quotient}, {eov, edz, er, eq});
        finish_op();
    endtask

    initial begin
        int lat;
        logic [7:0]  ra, rb;
        logic [15:0] rc;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        dividend  = '0;
        divisor   = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_state", {in_ready, out_valid, overflow, div_by_zero, remainder, quotient},
              {1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00});
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst_ready", in_ready, 1'b1);

        directed("basic",  16'h1234, 8'h56, 8'h36, 8'h10, 1'b0, 1'b0, NLAT);
        directed("maxq",   16'hFE01, 8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0, NLAT);
        directed("div1",   16'h00FF, 8'h01, 8'hFF, 8'h00, 1'b0, 1'b0, NLAT);
        directed("dbz",    16'h00AB, 8'h00, 8'hFF, 8'h00, 1'b1, 1'b0, 1);
        directed("ovf",    16'h1000, 8'h10, 8'hFF, 8'h00, 1'b0, 1'b1, 1);
        directed("after",  16'h0010, 8'h03, 8'h05, 8'h01, 1'b0, 1'b0, NLAT);

        // Backpressure: result must hold while out_ready is low.
        @(negedge clk);
        out_ready = 1'b0;
        run_op(16'h0064, 8'h07, lat);
        check("bp_lat", lat, NLAT);
        for (int i = 0; i < 5; i++) begin
            check("bp_hold", {out_valid, in_ready, remainder, quotient},
                  {1'b1, 1'b0, 8'h02, 8'h0E});
            @(posedge clk);
            #1;
        end
        finish_op();
        check("bp_release", {out_valid, in_ready, remainder, quotient},
              {1'b0, 1'b1, 8'h02, 8'h0E});

        // Reset in the middle of the iteration discards the operation.
        @(negedge clk);
        in_valid = 1'b1;
        dividend = 16'h1234;
        divisor  = 8'h56;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("rst_mid", {in_ready, out_valid, overflow, div_by_zero, remainder, quotient},
              {1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00});
        @(negedge clk);
        rst_n = 1'b1;
        repeat (NLAT + 2) @(posedge clk);
        #1;
        check("rst_noresult", out_valid, 1'b0);

        // Round-trips against products of the 8x8 multiplier.
        for (int i = 0; i < 1000; i++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(1, 255));
            rc = ra * rb;
            run_op(rc, rb, lat);
            check("rt", {lat[7:0], overflow, div_by_zero, remainder, quotient},
                  {8'(NLAT), 1'b0, 1'b0, 8'h00, ra});
            if (lat >= TMO) break;
            finish_op();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
